// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way request arbiter: requester count,
// FSM state encoding, idle grant value and the active-low grant decoder.
package arb_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDW  = 3;

    // All grant lines inactive (active-low bus)
    localparam logic [NREQ-1:0] GNT_N_RST = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // 3-to-8 active-low decode of a requester index, like a 74HC138
    function automatic logic [NREQ-1:0] decode_n(input logic [IDW-1:0] id);
        logic [NREQ-1:0] v;
        v     = GNT_N_RST;
        v[id] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin winner selection: the active-low request vector is rotated so
// that requester 'ptr' lands at position 0, a priority encoder finds the lowest
// active position, and the offset is added back to ptr to get the winner index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req_n,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;

    assign w_req = ~req_n;
    assign any   = |w_req;
    assign idx   = w_off + ptr;

    // Rotate requests so ptr has top priority, then encode the first active slot
    always_comb begin
        w_rot = '0;
        w_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_rot[k] = w_req[3'(k) + ptr];
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/req_arbiter8.sv
// 8-requester round-robin arbiter with active-low requests and grants.
// A grant lasts until the holder releases or MAX_HOLD cycles elapse; a forced
// revoke pulses timeout for one idle cycle. At least one idle cycle always
// separates two grants, and only idle cycles sample the request lines.
module req_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_n,
    output logic [NREQ-1:0] gnt_n,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    // Hold count value seen during the last permitted grant cycle
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t          r_state;
    logic [NREQ-1:0] r_gntN;
    logic [IDW-1:0]  r_gntId;
    logic            r_gntValid;
    logic            r_timeout;
    logic [IDW-1:0]  r_ptr;
    logic [7:0]      r_hold;

    state_t          w_stateNext;
    logic [NREQ-1:0] w_gntNNext;
    logic [IDW-1:0]  w_gntIdNext;
    logic            w_gntValidNext;
    logic            w_timeoutNext;
    logic [IDW-1:0]  w_ptrNext;
    logic [7:0]      w_holdNext;

    logic            w_any;
    logic [IDW-1:0]  w_idx;

    rr_pick8 u_pick (
        .req_n (req_n),
        .ptr   (r_ptr),
        .any   (w_any),
        .idx   (w_idx)
    );

    assign gnt_n     = r_gntN;
    assign gnt_id    = r_gntId;
    assign gnt_valid = r_gntValid;
    assign timeout   = r_timeout;

    // Register all state and outputs; reset wins over everything, even mid-grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gntN     <= GNT_N_RST;
            r_gntId    <= '0;
            r_gntValid <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold     <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_gntN     <= w_gntNNext;
            r_gntId    <= w_gntIdNext;
            r_gntValid <= w_gntValidNext;
            r_timeout  <= w_timeoutNext;
            r_ptr      <= w_ptrNext;
            r_hold     <= w_holdNext;
        end
    end

    // Next-state logic: arbitrate in IDLE; in GRANT release beats the hold limit
    always_comb begin
        w_stateNext    = r_state;
        w_gntNNext     = r_gntN;
        w_gntIdNext    = r_gntId;
        w_gntValidNext = r_gntValid;
        w_timeoutNext  = 1'b0;
        w_ptrNext      = r_ptr;
        w_holdNext     = r_hold;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_stateNext    = GRANT;
                    w_gntIdNext    = w_idx;
                    w_gntNNext     = decode_n(w_idx);
                    w_gntValidNext = 1'b1;
                    w_ptrNext      = w_idx + 3'd1;
                    w_holdNext     = '0;
                end
            end
            GRANT: begin
                if (req_n[r_gntId]) begin
                    w_stateNext    = IDLE;
                    w_gntNNext     = GNT_N_RST;
                    w_gntValidNext = 1'b0;
                end else if (r_hold == HOLD_LAST) begin
                    w_stateNext    = IDLE;
                    w_gntNNext     = GNT_N_RST;
                    w_gntValidNext = 1'b0;
                    w_timeoutNext  = 1'b1;
                end else begin
                    w_holdNext = r_hold + 8'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule
